// File: rtl/shared_reg_pkg.sv
// Shared definitions for the shared-register arbiter: FSM states,
// default sizing and a one-hot encode helper.
package shared_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 16;
  localparam int MAX_REQ     = 16;

  // One-hot encode an index into the widest supported request vector;
  // callers cast the result down to their own NUM_REQ width.
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
    logic [MAX_REQ-1:0] v;
    v = {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request bit
// searching circularly upward from ptr.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic               any,
  output logic [PW-1:0]      idx,
  output logic [NUM_REQ-1:0] onehot
);

  // Walk offsets from the far end back to zero so the closest hit to ptr wins.
  always_comb begin
    logic [PW:0]   cand;
    logic [PW-1:0] cidx;
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    cidx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (PW+1)'(i);
      // explicit wrap so non-power-of-2 NUM_REQ never indexes past the top requester
      cand = (cand >= (PW+1)'(NUM_REQ)) ? cand - (PW+1)'(NUM_REQ) : cand;
      cidx = cand[PW-1:0];
      idx  = req[cidx] ? cidx : idx;
      any  = any | req[cidx];
    end
    onehot = any ? NUM_REQ'(shared_reg_pkg::onehot(32'(idx))) : '0;
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared storage register.
// IDLE picks a requester, WRITE captures its data and pulses ack, HOLD keeps
// the grant for HOLD_CYCLES cycles before re-arbitrating.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                       clock,
  input  logic                       r,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         ack,
  output logic [WIDTH-1:0]           out,
  output logic                       out_valid,
  output logic [$clog2(NUM_REQ)-1:0] owner
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("shared_reg_arbiter: HOLD_CYCLES must be at least 1");
  end
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("shared_reg_arbiter: NUM_REQ must be in 2..16");
  end

  state_t              state;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       sel;
  logic [HW-1:0]       hold_cnt;

  logic                pick_any;
  logic [PW-1:0]       pick_idx;
  logic [NUM_REQ-1:0]  pick_oh;
  logic [NUM_REQ-1:0]  sel_oh;
  logic [PW-1:0]       ptr_next;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  // Grant vector of the latched winner and the pointer position after it.
  always_comb begin
    sel_oh   = NUM_REQ'(onehot(32'(sel)));
    if (sel == PW'(NUM_REQ - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = sel + PW'(1);
    end
  end

  // Arbitration FSM; every output is registered here.
  always_ff @(posedge clock) begin
    if (r) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      sel       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      ack       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      owner     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ack <= '0;
          if (pick_any) begin
            gnt   <= pick_oh;
            sel   <= pick_idx;
            state <= ST_WRITE;
          end else begin
            gnt   <= '0;
          end
        end
        ST_WRITE: begin
          // data is taken even if the requester has since dropped req
          out       <= wdata[sel*WIDTH +: WIDTH];
          ack       <= sel_oh;
          owner     <= sel;
          out_valid <= 1'b1;
          ptr       <= ptr_next;
          hold_cnt  <= HW'(HOLD_CYCLES - 1);
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          ack <= '0;
          if (hold_cnt == HW'(0)) begin
            gnt   <= '0;
            state <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: begin
          gnt   <= '0;
          ack   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter (NUM_REQ=4, WIDTH=16, HOLD_CYCLES=2).
// Directed phases push expected writes to a scoreboard; a monitor pops one
// entry per ack pulse and compares ack/out/owner/out_valid.
module tb_shared_reg_arbiter;

  localparam int NR = 4;
  localparam int W  = 16;

  typedef struct {
    int          idx;
    logic [15:0] data;
  } exp_t;

  logic          clock;
  logic          r;
  logic [NR-1:0] req;
  logic [NR*W-1:0] wdata;
  logic [NR-1:0] gnt;
  logic [NR-1:0] ack;
  logic [W-1:0]  out;
  logic          out_valid;
  logic [1:0]    owner;

  int   checks;
  int   errors;
  exp_t sb[$];

  shared_reg_arbiter #(
    .NUM_REQ     (NR),
    .WIDTH       (W),
    .HOLD_CYCLES (2)
  ) dut (
    .clock     (clock),
    .r         (r),
    .req       (req),
    .wdata     (wdata),
    .gnt       (gnt),
    .ack       (ack),
    .out       (out),
    .out_valid (out_valid),
    .owner     (owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_slice(input int k, input logic [15:0] v);
    wdata[k*W +: W] = v;
  endtask

  task automatic push(input int k, input logic [15:0] v);
    exp_t e;
    e.idx  = k;
    e.data = v;
    sb.push_back(e);
  endtask

  // Scoreboard monitor and invariant checks, sampled on the falling edge.
  always @(negedge clock) begin
    exp_t e;
    if (!r) begin
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("ack_onehot0", 32'($onehot0(ack)), 32'd1);
      check("ack_within_gnt", 32'(ack & ~gnt), 32'd0);
      if (ack != '0) begin
        if (sb.size() == 0) begin
          check("ack_unexpected", 32'(ack), 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_ack", 32'(ack), 32'd1 << e.idx);
          check("sb_out", 32'(out), 32'(e.data));
          check("sb_owner", 32'(owner), 32'(e.idx));
          check("sb_out_valid", 32'(out_valid), 32'd1);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    r      = 1'b1;
    req    = '0;
    wdata  = '0;

    // reset state
    tick();
    tick();
    r = 1'b0;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);

    // single request from requester 2
    set_slice(2, 16'hA5A5);
    req = 4'b0100;
    push(2, 16'hA5A5);
    tick();
    check("single_gnt_e0", 32'(gnt), 32'h4);
    check("single_ack_e0", 32'(ack), 32'h0);
    req = 4'b0000;
    tick();
    check("single_ack_e1", 32'(ack), 32'h4);
    check("single_out", 32'(out), 32'hA5A5);
    check("single_owner", 32'(owner), 32'd2);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_gnt_e1", 32'(gnt), 32'h4);
    tick();
    check("single_ack_e2", 32'(ack), 32'h0);
    check("single_gnt_e2", 32'(gnt), 32'h4);
    tick();
    check("single_gnt_e3", 32'(gnt), 32'h0);

    // request dropped during WRITE still completes (ptr 3 -> grant 1)
    set_slice(1, 16'h1B1B);
    req = 4'b0010;
    push(1, 16'h1B1B);
    tick();
    check("drop_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();
    check("drop_out", 32'(out), 32'h1B1B);
    check("drop_ack", 32'(ack), 32'h2);
    tick();
    tick();
    check("drop_idle_gnt", 32'(gnt), 32'h0);

    // pointer fairness: ptr=2, req 0 and 3 -> 3 before 0
    set_slice(0, 16'h0F0F);
    set_slice(3, 16'h3C3C);
    req = 4'b1001;
    push(3, 16'h3C3C);
    push(0, 16'h0F0F);
    tick();
    check("fair_first", 32'(gnt), 32'h8);
    req = 4'b0001;
    tick();
    tick();
    tick();
    check("fair_gap", 32'(gnt), 32'h0);
    tick();
    check("fair_second", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick();
    check("fair_out", 32'(out), 32'h0F0F);
    tick();
    tick();

    // HOLD stability and late request (ptr=1, requester 2 then 0)
    set_slice(2, 16'h5555);
    req = 4'b0100;
    push(2, 16'h5555);
    tick();
    check("hold_gnt", 32'(gnt), 32'h4);
    req = 4'b0000;
    tick();
    check("hold_out_e1", 32'(out), 32'h5555);
    wdata = {16'hFFFF, 16'hEEEE, 16'hDDDD, 16'hF0F0};
    req   = 4'b0001;
    push(0, 16'hF0F0);
    tick();
    check("hold_out_e2", 32'(out), 32'h5555);
    check("hold_gnt_e2", 32'(gnt), 32'h4);
    tick();
    check("hold_out_e3", 32'(out), 32'h5555);
    check("hold_wait_idle", 32'(gnt), 32'h0);
    tick();
    check("hold_late_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick();
    check("hold_late_out", 32'(out), 32'hF0F0);
    tick();
    tick();

    // full contention from ptr=0 after a reset
    r = 1'b1;
    tick();
    r = 1'b0;
    wdata = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    req   = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      logic [15:0] d;
      d = 16'h1111 * 16'(g % NR + 1);
      push(g % NR, d);
      tick();
      check("cont_gnt", 32'(gnt), 32'd1 << (g % NR));
      if (g == 4) begin
        req = 4'b0000;
      end
      tick();
      check("cont_out", 32'(out), 32'(d));
      tick();
      tick();
    end
    check("cont_idle", 32'(gnt), 32'h0);

    // reset in HOLD with out=3333; next arbitration restarts at ptr 0
    req = 4'b0100;
    push(2, 16'h3333);
    tick();
    req = 4'b0000;
    tick();
    check("mid_out", 32'(out), 32'h3333);
    tick();
    r = 1'b1;
    tick();
    r = 1'b0;
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    check("mid_rst_ack", 32'(ack), 32'h0);
    check("mid_rst_out", 32'(out), 32'h0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_owner", 32'(owner), 32'd0);
    req = 4'b1010;
    push(1, 16'h2222);
    tick();
    check("post_rst_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();
    check("post_rst_out", 32'(out), 32'h2222);
    tick();
    tick();
    tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
